// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the decode-side hazard controller: register-file
//   geometry, scoreboard counter width and the sequencing FSM encoding.
package hazard_ctrl_pkg;

    // Architectural integer registers; x0 is hard-wired and never tracked.
    localparam int NREG      = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    // Per-register pending-write counter. At most three writers can be in
    // flight behind decode (EX, MEM, WB), so two bits are enough.
    localparam int CNT_W     = 2;

    // Sequencing FSM. Encodings 2 and 3 are unused and recover to HZ_RUN.
    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_DRAIN = 2'd1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// hz_scoreboard
//   Per-register count of in-flight destination writes for x1..x31.
//   Ports:
//     clk, rst             core clock, async active-high reset
//     inc_en / inc_addr    an issuing instruction will write inc_addr
//     ret_en / ret_addr    WB writes ret_addr this cycle (pipe not frozen)
//     rd_a_addr, rd_b_addr two source-register lookups
//     busy_a, busy_b       source still has an outstanding write (with the
//                          WB write-through bypass applied)
//     sb_empty             no pending writes at all (registered, no bypass)
module hz_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_addr,
    input  logic                 ret_en,
    input  logic [REG_IDX_W-1:0] ret_addr,
    input  logic [REG_IDX_W-1:0] rd_a_addr,
    input  logic [REG_IDX_W-1:0] rd_b_addr,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic                 sb_empty
);

    logic [CNT_W-1:0] cnt [1:NREG-1];

    // NOTE: this counter array is a register bank, not a RAM, so it takes the
    // async reset; a reset must discard every pending write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every counter sees the same
            // pre-edge state regardless of loop order.
            for (int r = 1; r < NREG; r++) begin
                if ((inc_en && inc_addr == REG_IDX_W'(r)) &&
                    !(ret_en && ret_addr == REG_IDX_W'(r))) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if ((ret_en && ret_addr == REG_IDX_W'(r)) &&
                             !(inc_en && inc_addr == REG_IDX_W'(r))) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Counter lookups scan the bank so x0 never indexes outside it.
    logic [CNT_W-1:0] cnt_a, cnt_b;

    always_comb begin
        // NOTE: defaults first, so no path leaves these latched.
        cnt_a    = '0;
        cnt_b    = '0;
        sb_empty = 1'b1;
        for (int r = 1; r < NREG; r++) begin
            if (rd_a_addr == REG_IDX_W'(r)) cnt_a = cnt[r];
            if (rd_b_addr == REG_IDX_W'(r)) cnt_b = cnt[r];
            if (cnt[r] != '0)               sb_empty = 1'b0;
        end
    end

    // A register whose last outstanding write is retiring right now is
    // readable through the register-file write-through path.
    assign busy_a = (cnt_a != '0) &&
                    !(ret_en && ret_addr == rd_a_addr && cnt_a == CNT_W'(1));
    assign busy_b = (cnt_b != '0) &&
                    !(ret_en && ret_addr == rd_b_addr && cnt_b == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Decode-side sequencing controller for the 5-stage RV64I pipe. Decides
//   each cycle whether the ID instruction issues into EX or a bubble goes in.
//   Ports:
//     clk, rst                          core clock, async active-high reset
//     id_valid, id_serial               ID instruction present / system-fence
//     rs1_*/rs2_*/rd_*                  decoded register usage of ID
//     ex_flush                          EX redirect, kills ID
//     mem_busy                          memory outstanding, whole pipe holds
//     wb_valid, wb_rd_w_ena, wb_rd      WB register write
//     id_issue, if_stall, ex_bubble,
//     id_flush, freeze                  pipeline control
//     sb_empty, hz_state                scoreboard empty / FSM state (debug)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 rs1_r_ena,
    input  logic [REG_IDX_W-1:0] rs1_r_addr,
    input  logic                 rs2_r_ena,
    input  logic [REG_IDX_W-1:0] rs2_r_addr,
    input  logic                 rd_w_ena,
    input  logic [REG_IDX_W-1:0] rd_w_addr,
    input  logic                 id_serial,
    input  logic                 ex_flush,
    input  logic                 mem_busy,
    input  logic                 wb_valid,
    input  logic                 wb_rd_w_ena,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 id_issue,
    output logic                 if_stall,
    output logic                 ex_bubble,
    output logic                 id_flush,
    output logic                 freeze,
    output logic                 sb_empty,
    output logic [1:0]           hz_state
);

    hz_state_e state_q, state_d;
    logic      rs1_busy, rs2_busy;
    logic      retire, raw, issue, inc;

    // WB cannot retire while the pipe is frozen: the register stays in WB.
    assign retire = wb_valid && wb_rd_w_ena && (wb_rd != '0) && !mem_busy;

    hz_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (inc),
        .inc_addr  (rd_w_addr),
        .ret_en    (retire),
        .ret_addr  (wb_rd),
        .rd_a_addr (rs1_r_addr),
        .rd_b_addr (rs2_r_addr),
        .busy_a    (rs1_busy),
        .busy_b    (rs2_busy),
        .sb_empty  (sb_empty)
    );

    assign raw = (rs1_r_ena && (rs1_r_addr != '0) && rs1_busy) ||
                 (rs2_r_ena && (rs2_r_addr != '0) && rs2_busy);

    // Priority is mem_busy, then ex_flush, then hazards. A serial
    // instruction waits for an empty scoreboard in either state.
    assign issue = id_valid && !mem_busy && !ex_flush && !raw &&
                   (!id_serial || sb_empty);
    assign inc   = issue && rd_w_ena && (rd_w_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HZ_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = HZ_RUN;
        case (state_q)
            HZ_RUN: begin
                if (id_valid && id_serial && !sb_empty && !mem_busy && !ex_flush)
                    state_d = HZ_DRAIN;
            end
            HZ_DRAIN: begin
                // A redirect kills the serial instruction; a drained pipe lets
                // it issue this cycle. Under mem_busy nothing moves.
                if ((ex_flush && !mem_busy) || (sb_empty && !mem_busy))
                    state_d = HZ_RUN;
                else
                    state_d = HZ_DRAIN;
            end
            default: state_d = HZ_RUN;
        endcase
    end

    // Outputs are forced quiet while reset is held, even if the inputs
    // upstream are still active.
    assign id_issue  = !rst && issue;
    assign freeze    = !rst && mem_busy;
    assign id_flush  = !rst && ex_flush && !mem_busy;
    assign ex_bubble = !rst && !mem_busy && !issue;
    assign if_stall  = !rst && !mem_busy && !ex_flush && id_valid && !issue;
    assign hz_state  = state_q;

endmodule
